axis_stream_fifo: RTL and testbench
===================================

AXIS_STREAM_FIFO -- requirements
Module: axis_stream_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning tdata width in bits (multiple of 8, >= 8).
REQ-002 SHALL have parameter FIFO_DEPTH, default 64, meaning number of stored beats (power of 2, >= 4).
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have ports s_axis_tvalid in 1, s_axis_tready out 1, s_axis_tdata in DATA_WIDTH, s_axis_tkeep in DATA_WIDTH/8, s_axis_tlast in 1: the AXI-Stream slave input.
REQ-006 SHALL have ports m_axis_tvalid out 1, m_axis_tready in 1, m_axis_tdata out DATA_WIDTH, m_axis_tkeep out DATA_WIDTH/8, m_axis_tlast out 1: the AXI-Stream master output.
REQ-007 SHALL have ports full out 1, empty out 1, count out $clog2(FIFO_DEPTH)+1: fill status in beats.

Function
REQ-008 SHALL store each accepted beat as {tlast, tkeep, tdata} and output beats in acceptance order, unmodified.
REQ-009 SHALL accept a beat in any cycle where s_axis_tvalid && s_axis_tready; SHALL pop a beat in any cycle where m_axis_tvalid && m_axis_tready.
REQ-010 SHALL drive s_axis_tready = !full (registered-status based, no combinational path from m_axis_tready).
REQ-011 SHALL be first-word-fall-through: a beat accepted at edge N appears on m_axis with m_axis_tvalid high after edge N (latency 1 cycle into an empty FIFO).
REQ-012 SHALL hold m_axis_tdata/tkeep/tlast stable while m_axis_tvalid && !m_axis_tready; m_axis_tvalid SHALL NOT drop until the beat is popped.
REQ-013 SHALL use read/write pointers of $clog2(FIFO_DEPTH)+1 bits; address = low bits, wrap from FIFO_DEPTH-1 to 0 with MSB toggle.
REQ-014 SHALL set full when pointers differ only in MSB, empty when equal; count = wr_ptr - rd_ptr (modulo 2^(log2 depth+1)).
REQ-015 SHALL, on simultaneous accept and pop, leave count unchanged; when full, a pop frees one slot and s_axis_tready rises the following cycle only.
REQ-016 SHALL ignore s_axis_* while s_axis_tready is low and m_axis_tready while m_axis_tvalid is low (no pointer movement).

Reset
REQ-017 SHALL, while reset_n low, force pointers and count to 0, empty=1, full=0, m_axis_tvalid=0, s_axis_tready=0, asynchronously.
REQ-018 SHALL raise s_axis_tready on the first rising clk edge after reset_n deasserts; storage array is not reset.
REQ-019 SHALL, on reset mid-transfer, discard all stored beats, including partial packets; no beat is output after reset until a new one is accepted.

Configuration
REQ-020 SHALL support macro AXIS_FIFO_PACKET_MODE_EN; without it the block behaves per REQ-008..REQ-016 (cut-through).
REQ-021 With AXIS_FIFO_PACKET_MODE_EN defined, SHALL keep a complete-packet counter: +1 on accepting a tlast beat, -1 on popping a tlast beat, unchanged when both occur in one cycle.
REQ-022 With AXIS_FIFO_PACKET_MODE_EN defined, m_axis_tvalid SHALL be high only when !empty && (packet counter > 0 || full), the full term releasing a packet longer than FIFO_DEPTH to avoid deadlock.
REQ-023 With AXIS_FIFO_PACKET_MODE_EN defined, the packet counter SHALL reset to 0 with the pointers.

Verification
REQ-024 Single beat: reset, send tdata=0xA5A5A5A5, tkeep=0xF, tlast=1 with m_axis_tready=1 -> m_axis_tvalid high exactly one cycle later with identical fields; empty=1 afterwards.
REQ-025 Fill: m_axis_tready=0, push 64 beats 1..64 -> count=64, full=1, s_axis_tready=0; 65th beat held; one pop -> s_axis_tready=1 next cycle, beat 65 accepted, order 1..65 preserved.
REQ-026 Wrap/throughput: both sides ready continuously for 200 beats of incrementing data -> one beat per cycle, no gaps after first, output equals input, count stays 1.
REQ-027 Backpressure: random m_axis_tready (50%) over 500 beats with tkeep=0x7 on tlast beats -> no loss/duplication, outputs stable while stalled.
REQ-028 Packet mode (macro defined): push 3 beats without tlast -> m_axis_tvalid stays 0; push 4th with tlast=1 -> m_axis_tvalid rises next cycle; 70-beat packet -> released when full=1.
REQ-029 Reset mid-stream: assert reset_n low with count=10 -> outputs per REQ-017 immediately; after release count=0, empty=1.

Source files
------------

// File: rtl/axis_stream_fifo.sv
// ----------------------------------------------------------------------------
// axis_stream_fifo
//
// Single-clock, first-word-fall-through AXI-Stream FIFO. Each beat is stored
// as {tlast, tkeep, tdata} and emerges in acceptance order, unmodified.
//
// Build option:
//   AXIS_FIFO_PACKET_MODE_EN  - when defined, the master side only presents
//                               data once at least one complete packet (tlast
//                               beat) is stored, or when the FIFO is full. The
//                               full case releases packets longer than the
//                               FIFO so the stream cannot deadlock. When
//                               undefined, the FIFO is plain cut-through.
//
// Parameters:
//   DATA_WIDTH    tdata width in bits (multiple of 8, >= 8)
//   FIFO_DEPTH    number of stored beats (power of 2, >= 4)
//
// Ports:
//   clk            single clock, rising edge
//   reset_n        asynchronous active-low reset
//   s_axis_*       AXI-Stream slave (tvalid, tready, tdata, tkeep, tlast)
//   m_axis_*       AXI-Stream master (tvalid, tready, tdata, tkeep, tlast)
//   full           FIFO holds FIFO_DEPTH beats
//   empty          FIFO holds no beats
//   count          number of stored beats (0..FIFO_DEPTH)
// ----------------------------------------------------------------------------
module axis_stream_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 64
) (
    input  logic                            clk,
    input  logic                            reset_n,

    input  logic                            s_axis_tvalid,
    output logic                            s_axis_tready,
    input  logic [DATA_WIDTH-1:0]           s_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0]         s_axis_tkeep,
    input  logic                            s_axis_tlast,

    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic [DATA_WIDTH-1:0]           m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0]         m_axis_tkeep,
    output logic                            m_axis_tlast,

    output logic                            full,
    output logic                            empty,
    output logic [$clog2(FIFO_DEPTH):0]     count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int KW = DATA_WIDTH / 8;
    localparam int EW = DATA_WIDTH + KW + 1;

    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [EW-1:0] rd_entry;
    logic          ready_en;
    logic          push;
    logic          pop;
    logic          full_int;
    logic          empty_int;

    // Pointers carry one extra MSB: equal pointers mean empty, pointers that
    // differ only in the MSB mean full. Address is the low AW bits, so the
    // natural binary roll-over performs the wrap and MSB toggle.
    assign empty_int = (wr_ptr == rd_ptr);
    assign full_int  = (wr_ptr[AW] != rd_ptr[AW]) &&
                       (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign full  = full_int;
    assign empty = empty_int;
    assign count = wr_ptr - rd_ptr;

    // ready_en holds tready low during reset and releases it on the first
    // clock edge afterwards. tready depends only on registered state, so
    // there is no combinational path from m_axis_tready.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
        end
    end

    assign s_axis_tready = ready_en && !full_int;

    assign push = s_axis_tvalid && s_axis_tready;
    assign pop  = m_axis_tvalid && m_axis_tready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage is deliberately not reset; the pointers alone define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
        end
    end

    // Fall-through read: the head entry is visible as soon as it is written.
    assign rd_entry     = mem[rd_ptr[AW-1:0]];
    assign m_axis_tdata = rd_entry[DATA_WIDTH-1:0];
    assign m_axis_tkeep = rd_entry[DATA_WIDTH +: KW];
    assign m_axis_tlast = rd_entry[EW-1];

`ifdef AXIS_FIFO_PACKET_MODE_EN
    logic [AW:0] pkt_cnt;
    logic        push_last;
    logic        pop_last;

    assign push_last = push && s_axis_tlast;
    assign pop_last  = pop  && m_axis_tlast;

    // Number of complete packets (tlast beats) currently stored.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pkt_cnt <= '0;
        end else begin
            case ({push_last, pop_last})
                2'b10:   pkt_cnt <= pkt_cnt + 1'b1;
                2'b01:   pkt_cnt <= pkt_cnt - 1'b1;
                default: pkt_cnt <= pkt_cnt;
            endcase
        end
    end

    // The full term lets an oversize packet drain rather than stall forever.
    assign m_axis_tvalid = !empty_int && ((pkt_cnt != '0) || full_int);
`else
    assign m_axis_tvalid = !empty_int;
`endif

endmodule

// File: tb/tb_axis_stream_fifo.sv
module tb_axis_stream_fifo;

    localparam int DW    = 32;
    localparam int DEPTH = 64;
    localparam int BW    = DW + DW/8 + 1;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic [DW-1:0] s_axis_tdata;
    logic [3:0]    s_axis_tkeep;
    logic          s_axis_tlast;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic [DW-1:0] m_axis_tdata;
    logic [3:0]    m_axis_tkeep;
    logic          m_axis_tlast;
    logic          full;
    logic          empty;
    logic [6:0]    count;

    axis_stream_fifo #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
        .s_axis_tlast(s_axis_tlast),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
        .m_axis_tlast(m_axis_tlast),
        .full(full), .empty(empty), .count(count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: an ordered queue of stored beats {tlast, tkeep, tdata}.
    logic [BW-1:0] q[$];

    // Observed DUT values just before an edge, and model predictions for them.
    logic          o_s_ready, o_m_valid, o_full, o_empty;
    logic [BW-1:0] o_beat;
    logic [6:0]    o_count;
    int            exp_size;
    logic          exp_valid;
    logic [BW-1:0] exp_head;
    logic          did_push, did_pop;

    // Drive one cycle: apply inputs, sample at the falling edge, record the
    // model's predictions, advance the model by the observed handshakes.
    task automatic step(input logic sv, input logic [BW-1:0] sb, input logic mr);
        int pk;
        s_axis_tvalid = sv;
        {s_axis_tlast, s_axis_tkeep, s_axis_tdata} = sb;
        m_axis_tready = mr;
        @(negedge clk);
        o_s_ready = s_axis_tready;
        o_m_valid = m_axis_tvalid;
        o_beat    = {m_axis_tlast, m_axis_tkeep, m_axis_tdata};
        o_count   = count;
        o_full    = full;
        o_empty   = empty;
        exp_size  = q.size();
        exp_head  = (exp_size > 0) ? q[0] : '0;
        pk = 0;
        foreach (q[i]) if (q[i][BW-1]) pk++;
`ifdef AXIS_FIFO_PACKET_MODE_EN
        exp_valid = (exp_size > 0) && (pk > 0 || exp_size == DEPTH);
`else
        exp_valid = (exp_size > 0);
`endif
        did_pop  = o_m_valid && mr;
        did_push = o_s_ready && sv;
        if (did_pop && exp_size > 0) void'(q.pop_front());
        if (did_push) q.push_back(sb);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [BW-1:0] mk(input logic last, input logic [3:0] keep,
                                         input logic [DW-1:0] data);
        return {last, keep, data};
    endfunction

    task automatic test_reset();
        s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tkeep = '0;
        s_axis_tlast = 1'b0; m_axis_tready = 1'b0;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (count !== 7'd0)        begin n_err++; $display("FAIL reset_count got=%0d exp=0", count); end
        n_cmp++; if (empty !== 1'b1)        begin n_err++; $display("FAIL reset_empty got=%b exp=1", empty); end
        n_cmp++; if (full !== 1'b0)         begin n_err++; $display("FAIL reset_full got=%b exp=0", full); end
        n_cmp++; if (m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL reset_mvalid got=%b exp=0", m_axis_tvalid); end
        n_cmp++; if (s_axis_tready !== 1'b0) begin n_err++; $display("FAIL reset_sready got=%b exp=0", s_axis_tready); end
        reset_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (s_axis_tready !== 1'b0) begin n_err++; $display("FAIL release_sready_early got=%b exp=0", s_axis_tready); end
        @(posedge clk);
        #1;
        n_cmp++; if (s_axis_tready !== 1'b1) begin n_err++; $display("FAIL release_sready got=%b exp=1", s_axis_tready); end
        q.delete();
    endtask

    task automatic test_single_beat();
        logic [BW-1:0] b;
        b = mk(1'b1, 4'hF, 32'hA5A5A5A5);
        step(1'b1, b, 1'b1);
        n_cmp++; if (o_m_valid !== 1'b0) begin n_err++; $display("FAIL single_pre_valid got=%b exp=0", o_m_valid); end
        n_cmp++; if (did_push !== 1'b1)  begin n_err++; $display("FAIL single_accept got=%b exp=1", did_push); end
        step(1'b0, '0, 1'b1);
        n_cmp++; if (o_m_valid !== 1'b1) begin n_err++; $display("FAIL single_valid got=%b exp=1", o_m_valid); end
        n_cmp++; if (o_beat !== b)       begin n_err++; $display("FAIL single_beat got=%h exp=%h", o_beat, b); end
        step(1'b0, '0, 1'b1);
        n_cmp++; if (o_empty !== 1'b1)   begin n_err++; $display("FAIL single_empty got=%b exp=1", o_empty); end
        n_cmp++; if (o_m_valid !== 1'b0) begin n_err++; $display("FAIL single_post_valid got=%b exp=0", o_m_valid); end
    endtask

    task automatic test_fill();
        int got;
        for (int i = 1; i <= DEPTH; i++) begin
            step(1'b1, mk(1'b0, 4'hF, DW'(i)), 1'b0);
            n_cmp++; if (o_s_ready !== 1'b1) begin n_err++; $display("FAIL fill_ready beat=%0d got=%b exp=1", i, o_s_ready); end
            n_cmp++; if (o_count !== 7'(exp_size)) begin n_err++; $display("FAIL fill_count got=%0d exp=%0d", o_count, exp_size); end
        end
        step(1'b1, mk(1'b1, 4'hF, DW'(65)), 1'b0);
        n_cmp++; if (o_count !== 7'd64)  begin n_err++; $display("FAIL fill_count64 got=%0d exp=64", o_count); end
        n_cmp++; if (o_full !== 1'b1)    begin n_err++; $display("FAIL fill_full got=%b exp=1", o_full); end
        n_cmp++; if (o_s_ready !== 1'b0) begin n_err++; $display("FAIL fill_held got=%b exp=0", o_s_ready); end
        n_cmp++; if (o_m_valid !== exp_valid) begin n_err++; $display("FAIL fill_valid got=%b exp=%b", o_m_valid, exp_valid); end
        // Pop one while beat 65 waits; tready may only rise on the next cycle.
        step(1'b1, mk(1'b1, 4'hF, DW'(65)), 1'b1);
        n_cmp++; if (o_s_ready !== 1'b0) begin n_err++; $display("FAIL fill_pop_ready got=%b exp=0", o_s_ready); end
        n_cmp++; if (did_pop !== 1'b1)   begin n_err++; $display("FAIL fill_pop got=%b exp=1", did_pop); end
        step(1'b1, mk(1'b1, 4'hF, DW'(65)), 1'b0);
        n_cmp++; if (o_s_ready !== 1'b1) begin n_err++; $display("FAIL fill_reopen got=%b exp=1", o_s_ready); end
        got = 2;
        for (int c = 0; c < 200 && q.size() > 0; c++) begin
            step(1'b0, '0, 1'b1);
            n_cmp++; if (o_m_valid !== exp_valid) begin n_err++; $display("FAIL drain_valid got=%b exp=%b", o_m_valid, exp_valid); end
            if (o_m_valid) begin
                n_cmp++; if (o_beat[DW-1:0] !== DW'(got)) begin n_err++; $display("FAIL drain_order got=%0d exp=%0d", o_beat[DW-1:0], got); end
                got++;
            end
        end
        n_cmp++; if (got !== 66) begin n_err++; $display("FAIL drain_total got=%0d exp=66", got); end
    endtask

    task automatic test_back_to_back();
        int sent, rcvd;
        sent = 0; rcvd = 0;
        for (int c = 0; c < 260 && (sent < 200 || q.size() > 0); c++) begin
            step(sent < 200, mk(1'b1, 4'hF, DW'(1000 + sent)), 1'b1);
            n_cmp++; if (o_m_valid !== exp_valid) begin n_err++; $display("FAIL b2b_valid cyc=%0d got=%b exp=%b", c, o_m_valid, exp_valid); end
            if (exp_valid) begin
                n_cmp++; if (o_beat !== exp_head) begin n_err++; $display("FAIL b2b_data got=%h exp=%h", o_beat, exp_head); end
            end
            if (c > 0 && sent < 200) begin
                n_cmp++; if (o_count !== 7'd1) begin n_err++; $display("FAIL b2b_count got=%0d exp=1", o_count); end
            end
            n_cmp++; if (o_s_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready got=%b exp=1", o_s_ready); end
            if (did_push) sent++;
            if (did_pop) rcvd++;
        end
        n_cmp++; if (rcvd !== 200) begin n_err++; $display("FAIL b2b_total got=%0d exp=200", rcvd); end
    endtask

    task automatic test_backpressure();
        int sent, rcvd;
        logic prev_stall;
        logic [BW-1:0] prev_beat, b;
        logic last, sv;
        sent = 0; rcvd = 0; prev_stall = 1'b0; prev_beat = '0;
        for (int c = 0; c < 4000 && (sent < 500 || q.size() > 0); c++) begin
            last = (sent == 499) || ($urandom_range(0, 7) == 0);
            b  = mk(last, last ? 4'h7 : 4'hF, $urandom);
            sv = (sent < 500) && ($urandom_range(0, 3) != 0);
            step(sv, b, $urandom_range(0, 1) == 1);
            n_cmp++; if (o_m_valid !== exp_valid) begin n_err++; $display("FAIL bp_valid got=%b exp=%b", o_m_valid, exp_valid); end
            if (exp_valid) begin
                n_cmp++; if (o_beat !== exp_head) begin n_err++; $display("FAIL bp_data got=%h exp=%h", o_beat, exp_head); end
            end
            if (prev_stall) begin
                n_cmp++; if (o_m_valid !== 1'b1 || o_beat !== prev_beat) begin n_err++; $display("FAIL bp_stable got=%b/%h exp=1/%h", o_m_valid, o_beat, prev_beat); end
            end
            n_cmp++; if (o_s_ready !== (exp_size < DEPTH)) begin n_err++; $display("FAIL bp_ready got=%b exp=%b", o_s_ready, exp_size < DEPTH); end
            n_cmp++; if (o_count !== 7'(exp_size)) begin n_err++; $display("FAIL bp_count got=%0d exp=%0d", o_count, exp_size); end
            prev_stall = o_m_valid && !m_axis_tready;
            prev_beat  = o_beat;
            if (did_push) sent++;
            if (did_pop) rcvd++;
        end
        n_cmp++; if (rcvd !== 500) begin n_err++; $display("FAIL bp_total got=%0d exp=500", rcvd); end
    endtask

    task automatic test_reset_midstream();
        for (int i = 0; i < 10; i++) step(1'b1, mk(1'b0, 4'hF, DW'(i)), 1'b0);
        s_axis_tvalid = 1'b0;
        #1;
        n_cmp++; if (count !== 7'd10) begin n_err++; $display("FAIL mid_pre_count got=%0d exp=10", count); end
        reset_n = 1'b0;
        #1;
        n_cmp++; if (count !== 7'd0)         begin n_err++; $display("FAIL mid_count got=%0d exp=0", count); end
        n_cmp++; if (empty !== 1'b1)         begin n_err++; $display("FAIL mid_empty got=%b exp=1", empty); end
        n_cmp++; if (full !== 1'b0)          begin n_err++; $display("FAIL mid_full got=%b exp=0", full); end
        n_cmp++; if (m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL mid_mvalid got=%b exp=0", m_axis_tvalid); end
        n_cmp++; if (s_axis_tready !== 1'b0) begin n_err++; $display("FAIL mid_sready got=%b exp=0", s_axis_tready); end
        q.delete();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (s_axis_tready !== 1'b0) begin n_err++; $display("FAIL mid_release_early got=%b exp=0", s_axis_tready); end
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, '0, 1'b1);
            n_cmp++; if (o_m_valid !== 1'b0 || o_empty !== 1'b1 || o_count !== 7'd0) begin
                n_err++; $display("FAIL mid_after got=v%b e%b c%0d exp=v0 e1 c0", o_m_valid, o_empty, o_count);
            end
        end
    endtask

`ifdef AXIS_FIFO_PACKET_MODE_EN
    task automatic test_packet_mode();
        int sent, rcvd;
        logic saw_full_release;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, mk(1'b0, 4'hF, DW'(i)), 1'b1);
            n_cmp++; if (o_m_valid !== 1'b0) begin n_err++; $display("FAIL pkt_partial got=%b exp=0", o_m_valid); end
        end
        step(1'b1, mk(1'b1, 4'hF, DW'(3)), 1'b0);
        n_cmp++; if (o_m_valid !== 1'b0) begin n_err++; $display("FAIL pkt_before_last got=%b exp=0", o_m_valid); end
        step(1'b0, '0, 1'b0);
        n_cmp++; if (o_m_valid !== 1'b1) begin n_err++; $display("FAIL pkt_release got=%b exp=1", o_m_valid); end
        for (int c = 0; c < 20 && q.size() > 0; c++) step(1'b0, '0, 1'b1);
        sent = 0; rcvd = 0; saw_full_release = 1'b0;
        for (int c = 0; c < 400 && (sent < 70 || q.size() > 0); c++) begin
            step(sent < 70, mk(sent == 69, 4'hF, DW'(sent)), 1'b1);
            n_cmp++; if (o_m_valid !== exp_valid) begin n_err++; $display("FAIL pkt_long_valid got=%b exp=%b", o_m_valid, exp_valid); end
            if (exp_valid) begin
                n_cmp++; if (o_beat !== exp_head) begin n_err++; $display("FAIL pkt_long_data got=%h exp=%h", o_beat, exp_head); end
            end
            if (o_m_valid && o_full && rcvd == 0) saw_full_release = 1'b1;
            if (did_push) sent++;
            if (did_pop) rcvd++;
        end
        n_cmp++; if (saw_full_release !== 1'b1) begin n_err++; $display("FAIL pkt_full_release got=0 exp=1"); end
        n_cmp++; if (rcvd !== 70) begin n_err++; $display("FAIL pkt_long_total got=%0d exp=70", rcvd); end
    endtask
`endif

    initial begin
        test_reset();
        test_single_beat();
        test_fill();
        test_back_to_back();
        test_backpressure();
        test_reset_midstream();
`ifdef AXIS_FIFO_PACKET_MODE_EN
        test_packet_mode();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
